// File: rtl/rgb_frame_source.sv
// rgb_frame_source: streams a WIDTH x HEIGHT frame from a 1-cycle-latency read port over a vld/busy handshake
module rgb_frame_source #(
  parameter int WIDTH  = 256,
  parameter int HEIGHT = 256,
  parameter int ADDR_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_active,
  output logic              o_done,
  output logic              o_mem_rd,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [23:0]       i_mem_rdata,
  output logic              o_rgb_vld,
  output logic [23:0]       o_rgb_data,
  input  logic              i_rgb_busy
);
  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int PW = $clog2(TOTAL + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [PW-1:0] rd_cnt, pix_cnt;
  logic [ADDR_W-1:0] addr;
  logic [23:0] fifo [2];
  logic [1:0] count;
  logic wr_ptr, rd_ptr, in_flight, pop, last_rd, last_px;
  assign pop = o_rgb_vld && !i_rgb_busy;
  assign last_rd = rd_cnt == PW'(TOTAL - 1);
  assign last_px = pix_cnt == PW'(TOTAL - 1);
  assign o_mem_rd = state == RUN && 3'(count) + 3'(in_flight) < 3'd2 + 3'(pop);
  assign o_mem_addr = addr;
  assign o_active = state == RUN || state == DRAIN;
  assign o_done = state == DONE;
  assign o_rgb_vld = count != 2'd0;
  assign o_rgb_data = fifo[rd_ptr];
  always_comb begin
    state_n = state;
    if (state == IDLE && i_start) state_n = RUN;
    if (state == RUN && o_mem_rd && last_rd) state_n = DRAIN;
    if (state == DRAIN && pop && last_px) state_n = DONE;
    if (state == DONE) state_n = IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      rd_cnt <= '0;
      pix_cnt <= '0;
      addr <= '0;
      in_flight <= 1'b0;
    end else begin
      state <= state_n;
      in_flight <= o_mem_rd;
      if (state == IDLE && i_start) begin
        rd_cnt <= '0;
        pix_cnt <= '0;
        addr <= '0;
      end else begin
        if (o_mem_rd) rd_cnt <= rd_cnt + PW'(1);
        if (o_mem_rd && !last_rd) addr <= addr + ADDR_W'(1);
        if (pop) pix_cnt <= pix_cnt + PW'(1);
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fifo[0] <= '0;
      fifo[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count <= '0;
    end else begin
      if (in_flight) fifo[wr_ptr] <= i_mem_rdata;
      if (in_flight) wr_ptr <= ~wr_ptr;
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(in_flight) - 2'(pop);
    end
  end
endmodule
